// File: rtl/ins_dec_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU function codes, branch
// condition codes and the packed decode-result bundle.
package ins_dec_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned FS_W     = 4;
  localparam int unsigned F3_W     = 3;

  // Major opcodes (IR[6:0])
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // ALU function select, shared with the ALU
  localparam logic [FS_W-1:0] FS_ADD   = 4'b0000;
  localparam logic [FS_W-1:0] FS_SLL   = 4'b0001;
  localparam logic [FS_W-1:0] FS_SLT   = 4'b0010;
  localparam logic [FS_W-1:0] FS_SLTU  = 4'b0011;
  localparam logic [FS_W-1:0] FS_XOR   = 4'b0100;
  localparam logic [FS_W-1:0] FS_SRL   = 4'b0101;
  localparam logic [FS_W-1:0] FS_OR    = 4'b0110;
  localparam logic [FS_W-1:0] FS_AND   = 4'b0111;
  localparam logic [FS_W-1:0] FS_SUB   = 4'b1000;
  localparam logic [FS_W-1:0] FS_SRA   = 4'b1101;
  localparam logic [FS_W-1:0] FS_PASSB = 4'b1111;

  // Branch mode conditions (identical to branch funct3)
  localparam logic [F3_W-1:0] BMC_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] BMC_BNE  = 3'b001;
  localparam logic [F3_W-1:0] BMC_BLT  = 3'b100;
  localparam logic [F3_W-1:0] BMC_BGE  = 3'b101;
  localparam logic [F3_W-1:0] BMC_BLTU = 3'b110;
  localparam logic [F3_W-1:0] BMC_BGEU = 3'b111;

  // Full decode result; field order matches the top-level port order
  typedef struct packed {
    logic              ma;
    logic              mb;
    logic              md;
    logic              rw;
    logic              mw;
    logic              mr;
    logic              pl;
    logic              jl;
    logic              jlr;
    logic              br;
    logic [FS_W-1:0]   fs;
    logic [F3_W-1:0]   bmc;
    logic [REG_AW-1:0] aa;
    logic [REG_AW-1:0] ba;
    logic [REG_AW-1:0] da;
  } dec_t;

  // funct3 maps straight onto the low FS bits; alt selects SUB/SRA
  function automatic logic [FS_W-1:0] alu_fs(input logic alt, input logic [F3_W-1:0] f3);
    return {alt, f3};
  endfunction

endpackage

// File: rtl/ins_dec_comb.sv
// Purely combinational RV32I decode of one instruction word.
// Ports: ir_i  - instruction word
//        dec_c - unregistered decode result (all zero for illegal encodings)
module ins_dec_comb
  import ins_dec_pkg::*;
(
  input  logic [XLEN-1:0] ir_i,
  output dec_t            dec_c
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [F3_W-1:0]   funct3;
  logic              f7b;
  logic              unused_ir;

  assign opcode    = ir_i[6:0];
  assign rd        = ir_i[11:7];
  assign funct3    = ir_i[14:12];
  assign rs1       = ir_i[19:15];
  assign rs2       = ir_i[24:20];
  assign f7b       = ir_i[30];
  assign unused_ir = ^{ir_i[31], ir_i[29:25]};

  // Anything not explicitly recognised falls through as an all-zero NOP
  always_comb begin
    dec_t d;
    d = '0;
    unique case (opcode)
      OPC_LUI: begin
        d.rw = 1'b1;
        d.mb = 1'b1;
        d.fs = FS_PASSB;
        d.da = rd;
      end
      OPC_AUIPC: begin
        d.rw = 1'b1;
        d.ma = 1'b1;
        d.mb = 1'b1;
        d.fs = FS_ADD;
        d.da = rd;
      end
      OPC_JAL: begin
        d.rw = 1'b1;
        d.ma = 1'b1;
        d.mb = 1'b1;
        d.pl = 1'b1;
        d.jl = 1'b1;
        d.fs = FS_ADD;
        d.da = rd;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          d.rw  = 1'b1;
          d.mb  = 1'b1;
          d.pl  = 1'b1;
          d.jlr = 1'b1;
          d.fs  = FS_ADD;
          d.aa  = rs1;
          d.da  = rd;
        end
      end
      OPC_BRANCH: begin
        // funct3 010/011 are unassigned branch encodings
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          d.br  = 1'b1;
          d.pl  = 1'b1;
          d.fs  = FS_SUB;
          d.bmc = funct3;
          d.aa  = rs1;
          d.ba  = rs2;
        end
      end
      OPC_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          d.rw = 1'b1;
          d.mb = 1'b1;
          d.mr = 1'b1;
          d.md = 1'b1;
          d.fs = FS_ADD;
          d.aa = rs1;
          d.da = rd;
        end
      end
      OPC_STORE: begin
        if (!funct3[2] && funct3 != 3'b011) begin
          d.mw = 1'b1;
          d.mb = 1'b1;
          d.fs = FS_ADD;
          d.aa = rs1;
          d.ba = rs2;
        end
      end
      OPC_OPIMM: begin
        // Immediate bit 30 only means "arithmetic" for SRAI
        d.rw = 1'b1;
        d.mb = 1'b1;
        d.fs = alu_fs(f7b && (funct3 == 3'b101), funct3);
        d.aa = rs1;
        d.da = rd;
      end
      OPC_OP: begin
        if (!f7b || funct3 == 3'b000 || funct3 == 3'b101) begin
          d.rw = 1'b1;
          d.fs = alu_fs(f7b, funct3);
          d.aa = rs1;
          d.ba = rs2;
          d.da = rd;
        end
      end
      default: ;
    endcase
    dec_c = d;
  end

endmodule

// File: rtl/ins_dec.sv
// Registered RV32I instruction decoder: decodes IR combinationally and
// presents the result one clock later.
// Ports: clk, rst_n (async active-low) | IR instruction word |
//        MA/MB/MD mux selects, RW/MW/MR strobes, PL/JL/JLR/BR PC control,
//        FS ALU function, BMC branch condition, AA/BA/DA register addresses.
module ins_dec
  import ins_dec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   IR,
  output logic              MA,
  output logic              MB,
  output logic              MD,
  output logic              RW,
  output logic              MW,
  output logic              MR,
  output logic              PL,
  output logic              JL,
  output logic              JLR,
  output logic              BR,
  output logic [FS_W-1:0]   FS,
  output logic [F3_W-1:0]   BMC,
  output logic [REG_AW-1:0] AA,
  output logic [REG_AW-1:0] BA,
  output logic [REG_AW-1:0] DA
);

  dec_t dec_d;
  dec_t dec_q;

  ins_dec_comb u_comb (
    .ir_i  (IR),
    .dec_c (dec_d)
  );

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign MA  = dec_q.ma;
  assign MB  = dec_q.mb;
  assign MD  = dec_q.md;
  assign RW  = dec_q.rw;
  assign MW  = dec_q.mw;
  assign MR  = dec_q.mr;
  assign PL  = dec_q.pl;
  assign JL  = dec_q.jl;
  assign JLR = dec_q.jlr;
  assign BR  = dec_q.br;
  assign FS  = dec_q.fs;
  assign BMC = dec_q.bmc;
  assign AA  = dec_q.aa;
  assign BA  = dec_q.ba;
  assign DA  = dec_q.da;

endmodule

// File: tb/tb_ins_dec.sv
// Scoreboard bench for ins_dec: directed instruction words with hand-computed
// expected decodes, compared one cycle after each word is applied.
module tb_ins_dec;
  import ins_dec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] IR;
  logic        MA, MB, MD, RW, MW, MR, PL, JL, JLR, BR;
  logic [3:0]  FS;
  logic [2:0]  BMC;
  logic [4:0]  AA, BA, DA;

  int unsigned n_pass;
  int unsigned n_total;

  dec_t        exp_q[$];
  logic [31:0] ir_q[$];

  ins_dec dut (
    .clk(clk), .rst_n(rst_n), .IR(IR),
    .MA(MA), .MB(MB), .MD(MD), .RW(RW), .MW(MW), .MR(MR),
    .PL(PL), .JL(JL), .JLR(JLR), .BR(BR),
    .FS(FS), .BMC(BMC), .AA(AA), .BA(BA), .DA(DA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic dec_t actual();
    return {MA, MB, MD, RW, MW, MR, PL, JL, JLR, BR, FS, BMC, AA, BA, DA};
  endfunction

  // ctl bit order: {MA,MB,MD,RW,MW,MR,PL,JL,JLR,BR}
  function automatic dec_t mk(input logic [9:0] ctl, input logic [3:0] fs,
                              input logic [2:0] bmc, input logic [4:0] aa,
                              input logic [4:0] ba, input logic [4:0] da);
    return {ctl, fs, bmc, aa, ba, da};
  endfunction

  task automatic check(input string name, input dec_t act, input dec_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got ctl=%b fs=%b bmc=%b aa=%0d ba=%0d da=%0d, want ctl=%b fs=%b bmc=%b aa=%0d ba=%0d da=%0d",
                  name, act[31:22], act.fs, act.bmc, act.aa, act.ba, act.da,
                  exp[31:22], exp.fs, exp.bmc, exp.aa, exp.ba, exp.da);
  endtask

  task automatic apply(input logic [31:0] ir, input dec_t exp);
    @(negedge clk);
    IR = ir;
    ir_q.push_back(ir);
    exp_q.push_back(exp);
  endtask

  // Monitor: each rising edge presents the decode of the word applied before it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() != 0) begin
        dec_t        e;
        logic [31:0] w;
        e = exp_q.pop_front();
        w = ir_q.pop_front();
        check($sformatf("dec_%08h", w), actual(), e);
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    IR      = 32'h006283B3;

    // Held in reset: outputs stay zero across clock edges
    #2;
    check("reset_hold_a", actual(), '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_b", actual(), '0);

    // Release between edges: still zero until the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_release_pre_edge", actual(), '0);
    ir_q.push_back(32'h006283B3);
    exp_q.push_back(mk(10'b0001000000, FS_ADD, 3'd0, 5'd5, 5'd6, 5'd7));

    apply(32'h406283B3, mk(10'b0001000000, FS_SUB,   3'd0, 5'd5, 5'd6, 5'd7)); // SUB
    apply(32'h4062D3B3, mk(10'b0001000000, FS_SRA,   3'd0, 5'd5, 5'd6, 5'd7)); // SRA
    apply(32'h4062C3B3, '0);                                                   // OP illegal f7b
    apply(32'h4002D393, mk(10'b0101000000, FS_SRA,   3'd0, 5'd5, 5'd0, 5'd7)); // SRAI
    apply(32'h40028393, mk(10'b0101000000, FS_ADD,   3'd0, 5'd5, 5'd0, 5'd7)); // ADDI bit30
    apply(32'hFFF2B393, mk(10'b0101000000, FS_SLTU,  3'd0, 5'd5, 5'd0, 5'd7)); // SLTIU -1
    apply(32'h0002A383, mk(10'b0111010000, FS_ADD,   3'd0, 5'd5, 5'd0, 5'd7)); // LW
    apply(32'h0002B383, '0);                                                   // LOAD f3=011
    apply(32'h0062A023, mk(10'b0100100000, FS_ADD,   3'd0, 5'd5, 5'd6, 5'd0)); // SW
    apply(32'h0062B023, '0);                                                   // STORE f3=011
    apply(32'h00629063, mk(10'b0000001001, FS_SUB,   BMC_BNE,  5'd5, 5'd6, 5'd0)); // BNE
    apply(32'h0062F063, mk(10'b0000001001, FS_SUB,   BMC_BGEU, 5'd5, 5'd6, 5'd0)); // BGEU
    apply(32'h0062A063, '0);                                                   // BRANCH f3=010
    apply(32'h000003EF, mk(10'b1101001100, FS_ADD,   3'd0, 5'd0, 5'd0, 5'd7)); // JAL
    apply(32'h000280E7, mk(10'b0101001010, FS_ADD,   3'd0, 5'd5, 5'd0, 5'd1)); // JALR
    apply(32'h000290E7, '0);                                                   // JALR f3=001
    apply(32'h123452B7, mk(10'b0101000000, FS_PASSB, 3'd0, 5'd0, 5'd0, 5'd5)); // LUI
    apply(32'h00001317, mk(10'b1101000000, FS_ADD,   3'd0, 5'd0, 5'd0, 5'd6)); // AUIPC
    apply(32'h0000007F, '0);                                                   // illegal opcode
    apply(32'h006283B3, mk(10'b0001000000, FS_ADD,   3'd0, 5'd5, 5'd6, 5'd7)); // ADD again

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, want 0", exp_q.size());

    // Asynchronous assertion clears the held ADD decode without a clock edge
    @(negedge clk);
    #2;
    check("pre_async_reset", actual(), mk(10'b0001000000, FS_ADD, 3'd0, 5'd5, 5'd6, 5'd7));
    rst_n = 1'b0;
    #1;
    check("async_reset", actual(), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
